// File: rtl/spi_pkg.sv
// Shared types and mode decoding for the SPI slave.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam logic SAMPLE_RISE = 1'b1;
  localparam logic SAMPLE_FALL = 1'b0;

  // Data is sampled on the rising sck edge when CPOL and CPHA agree.
  function automatic logic sample_edge(input int unsigned cpol, input int unsigned cpha);
    return (cpol == cpha) ? SAMPLE_RISE : SAMPLE_FALL;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with a configurable reset level.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled in the clk domain, with tx holding register and rx output register.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CPOL      = 0,
  parameter int unsigned CPHA      = 0,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sck,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             overrun,
  output logic             underrun,
  output logic             busy
);

  localparam int unsigned   CW         = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
  localparam logic          SAMPLE_SEL = sample_edge(CPOL, CPHA);

  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  logic sck_s, cs_s, mosi_s, sck_d, cs_d;
  logic [1:0] settle;

  sync2 #(.RESET_VAL(CPOL != 0)) u_sync_sck  (.clk(clk), .reset_n(reset_n), .d(sck),  .q(sck_s));
  sync2 #(.RESET_VAL(1'b1))      u_sync_cs   (.clk(clk), .reset_n(reset_n), .d(cs_n), .q(cs_s));
  sync2 #(.RESET_VAL(1'b0))      u_sync_mosi (.clk(clk), .reset_n(reset_n), .d(mosi), .q(mosi_s));

  // settle masks the artificial cs_n fall seen when reset releases with cs_n already low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_d  <= (CPOL != 0);
      cs_d   <= 1'b1;
      settle <= 2'd0;
    end else begin
      sck_d  <= sck_s;
      cs_d   <= cs_s;
      settle <= (settle == 2'd3) ? settle : settle + 2'd1;
    end
  end

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg, hold, rx_sh, rx_next, load_word;
  logic             hold_full, und_pend, miso_q;
  logic             sck_rise, sck_fall, sample_ev, shift_ev, cs_fall, cs_rise;
  logic             load, load_empty, tx_accept;

  assign sck_rise   = sck_s & ~sck_d;
  assign sck_fall   = ~sck_s & sck_d;
  assign sample_ev  = SAMPLE_SEL ? sck_rise : sck_fall;
  assign shift_ev   = SAMPLE_SEL ? sck_fall : sck_rise;
  assign cs_fall    = cs_d & ~cs_s & (settle == 2'd3);
  assign cs_rise    = cs_s & ~cs_d;

  assign tx_ready   = ~hold_full;
  assign tx_accept  = tx_valid & ~hold_full;
  assign load       = ((state == IDLE) & cs_fall) |
                      ((state == ACTIVE) & ~cs_rise & sample_ev & (cnt == LAST_BIT));
  assign load_word  = hold_full ? hold : (tx_valid ? tx_data : '0);
  assign load_empty = ~hold_full & ~tx_valid;
  assign rx_next    = (MSB_FIRST != 0) ? {rx_sh[WIDTH-2:0], mosi_s} : {mosi_s, rx_sh[WIDTH-1:1]};

  assign miso_oe    = ~cs_s;
  assign miso       = miso_q & miso_oe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      und_pend  <= 1'b0;
      miso_q    <= 1'b0;
      rx_sh     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
      if (tx_accept && !load) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      // A zero-filled word is only reported once it actually starts shifting.
      if (load) begin
        hold_full <= 1'b0;
        und_pend  <= load_empty;
        if (CPHA == 0) begin
          miso_q <= head(load_word);
          shreg  <= advance(load_word);
        end else begin
          shreg  <= load_word;
        end
      end
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state <= ACTIVE;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
            und_pend <= 1'b0;
            miso_q   <= 1'b0;
          end else begin
            if (sample_ev) begin
              rx_sh <= rx_next;
              if (und_pend && cnt == '0) begin
                underrun <= 1'b1;
                und_pend <= 1'b0;
              end
              if (cnt == LAST_BIT) begin
                cnt      <= '0;
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                overrun  <= rx_valid & ~rx_ready;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            // With CPHA=0 the word's first bit was already driven at load time.
            if (shift_ev && (CPHA != 0 || cnt != '0)) begin
              miso_q <= head(shreg);
              shreg  <= advance(shreg);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench: four 8-bit instances (modes 0..3) and one 16-bit LSB-first instance.
module tb_spi_slave_sync;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] sck, cs_n, mosi, tx_valid, rx_ready;
  logic [7:0] tx8 [4];
  logic [15:0] tx16;
  wire  [4:0] miso, miso_oe, tx_ready, rx_valid, overrun, underrun, busy;
  wire  [7:0] rx8 [4];
  wire [15:0] rx16;

  int n_cmp = 0;
  int n_bad = 0;
  int un_cnt [5];
  int ov_cnt [5];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_mode
    spi_slave_sync #(.WIDTH(8), .CPOL(i / 2), .CPHA(i % 2), .MSB_FIRST(1)) u_dut (
      .clk(clk), .reset_n(reset_n), .sck(sck[i]), .cs_n(cs_n[i]), .mosi(mosi[i]),
      .miso(miso[i]), .miso_oe(miso_oe[i]), .tx_data(tx8[i]), .tx_valid(tx_valid[i]),
      .tx_ready(tx_ready[i]), .rx_data(rx8[i]), .rx_valid(rx_valid[i]),
      .rx_ready(rx_ready[i]), .overrun(overrun[i]), .underrun(underrun[i]), .busy(busy[i])
    );
  end

  spi_slave_sync #(.WIDTH(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .sck(sck[4]), .cs_n(cs_n[4]), .mosi(mosi[4]),
    .miso(miso[4]), .miso_oe(miso_oe[4]), .tx_data(tx16), .tx_valid(tx_valid[4]),
    .tx_ready(tx_ready[4]), .rx_data(rx16), .rx_valid(rx_valid[4]),
    .rx_ready(rx_ready[4]), .overrun(overrun[4]), .underrun(underrun[4]), .busy(busy[4])
  );

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (overrun[i])  ov_cnt[i]++;
      if (underrun[i]) un_cnt[i]++;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int idx, input logic [31:0] d);
    @(negedge clk);
    if (idx < 4) tx8[idx] = d[7:0];
    else tx16 = d[15:0];
    tx_valid[idx] = 1'b1;
    @(negedge clk);
    tx_valid[idx] = 1'b0;
  endtask

  task automatic cs_low(input int idx);
    @(negedge clk);
    cs_n[idx] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high(input int idx);
    repeat (2) @(negedge clk);
    cs_n[idx] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic consume(input int idx);
    @(negedge clk);
    rx_ready[idx] = 1'b1;
    @(negedge clk);
    rx_ready[idx] = 1'b0;
  endtask

  // Master side of one word (or nbits of it), as a real SPI master would drive it.
  task automatic xfer(input int idx, input int nbits, input int width,
                      input logic [31:0] txw, output logic [31:0] rxw);
    logic cpol, cpha, msb;
    int   b;
    cpol = (idx < 4) ? idx[1] : 1'b0;
    cpha = (idx < 4) ? idx[0] : 1'b0;
    msb  = (idx < 4);
    rxw  = '0;
    for (int i = 0; i < nbits; i++) begin
      b = msb ? width - 1 - i : i;
      if (!cpha) begin
        mosi[idx] = txw[b];
        repeat (H) @(negedge clk);
        sck[idx] = ~cpol;
        rxw[b]   = miso[idx];
        repeat (H) @(negedge clk);
        sck[idx] = cpol;
      end else begin
        sck[idx]  = ~cpol;
        mosi[idx] = txw[b];
        repeat (H) @(negedge clk);
        sck[idx] = cpol;
        rxw[b]   = miso[idx];
        repeat (H) @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [31:0] r, r1, r2, r3;
    int u0, o0;
    reset_n  = 1'b0;
    sck      = 5'b01100;
    cs_n     = '1;
    mosi     = '0;
    tx_valid = '0;
    rx_ready = '0;
    for (int i = 0; i < 4; i++) tx8[i] = '0;
    tx16 = '0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    check("rst_tx_ready", tx_ready, 5'b11111);
    check("rst_rx_valid", rx_valid, 5'b00000);
    check("rst_rx_data0", rx8[0], 8'h00);
    check("rst_miso", miso, 5'b00000);
    check("rst_miso_oe", miso_oe, 5'b00000);
    check("rst_busy", busy, 5'b00000);
    check("rst_overrun", overrun, 5'b00000);
    check("rst_underrun", underrun, 5'b00000);

    // sck toggling while deselected must be ignored
    for (int i = 0; i < 4; i++) begin
      repeat (H) @(negedge clk);
      sck[0] = ~sck[0];
    end
    repeat (H) @(negedge clk);
    check("idle_sck_rx_valid", rx_valid[0], 1'b0);
    check("idle_sck_busy", busy[0], 1'b0);

    // Mode 0 basic exchange
    u0 = un_cnt[0]; o0 = ov_cnt[0];
    push(0, 32'hA5);
    check("m0_hold_full", tx_ready[0], 1'b0);
    cs_low(0);
    check("m0_busy", busy[0], 1'b1);
    check("m0_miso_oe", miso_oe[0], 1'b1);
    xfer(0, 8, 8, 32'h3C, r);
    cs_high(0);
    check("m0_master_rx", r, 32'hA5);
    check("m0_rx_data", rx8[0], 8'h3C);
    check("m0_rx_valid", rx_valid[0], 1'b1);
    check("m0_overrun", ov_cnt[0] - o0, 0);
    check("m0_underrun", un_cnt[0] - u0, 0);
    check("m0_busy_end", busy[0], 1'b0);
    consume(0);
    check("m0_consumed", rx_valid[0], 1'b0);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      push(m, 32'h81);
      cs_low(m);
      xfer(m, 8, 8, 32'h7E, r);
      cs_high(m);
      check($sformatf("mode%0d_master_rx", m), r, 32'h81);
      check($sformatf("mode%0d_rx_data", m), rx8[m], 8'h7E);
      check($sformatf("mode%0d_rx_valid", m), rx_valid[m], 1'b1);
    end

    // Burst of three, holding register refilled once after the first word
    u0 = un_cnt[0]; o0 = ov_cnt[0];
    rx_ready[0] = 1'b1;
    push(0, 32'hC3);
    cs_low(0);
    xfer(0, 8, 8, 32'h11, r1);
    push(0, 32'h96);
    xfer(0, 8, 8, 32'h22, r2);
    xfer(0, 8, 8, 32'h33, r3);
    cs_high(0);
    rx_ready[0] = 1'b0;
    check("burst_w1", r1, 32'hC3);
    check("burst_w2", r2, 32'h00);
    check("burst_w3", r3, 32'h96);
    check("burst_underrun", un_cnt[0] - u0, 1);
    check("burst_overrun", ov_cnt[0] - o0, 0);
    check("burst_rx_data", rx8[0], 8'h33);
    check("burst_rx_valid", rx_valid[0], 1'b0);

    // Overrun: two words while the consumer stalls
    o0 = ov_cnt[0];
    push(0, 32'h01);
    cs_low(0);
    xfer(0, 8, 8, 32'h11, r);
    cs_high(0);
    push(0, 32'h02);
    cs_low(0);
    xfer(0, 8, 8, 32'h22, r);
    cs_high(0);
    check("ovr_rx_data", rx8[0], 8'h22);
    check("ovr_pulses", ov_cnt[0] - o0, 1);
    check("ovr_rx_valid", rx_valid[0], 1'b1);
    consume(0);

    // Abort after 5 bits, then a clean frame
    u0 = un_cnt[0];
    push(0, 32'h3C);
    cs_low(0);
    xfer(0, 5, 8, 32'hFF, r);
    cs_high(0);
    check("abort_rx_valid", rx_valid[0], 1'b0);
    check("abort_tx_consumed", tx_ready[0], 1'b1);
    push(0, 32'hF0);
    cs_low(0);
    xfer(0, 8, 8, 32'h5A, r);
    cs_high(0);
    check("after_abort_master_rx", r, 32'hF0);
    check("after_abort_rx_data", rx8[0], 8'h5A);
    check("after_abort_rx_valid", rx_valid[0], 1'b1);
    check("after_abort_underrun", un_cnt[0] - u0, 0);

    // 16-bit LSB-first
    push(4, 32'h1234);
    cs_low(4);
    xfer(4, 16, 16, 32'hBEEF, r);
    cs_high(4);
    check("w16_master_rx", r, 32'h1234);
    check("w16_rx_data", rx16, 16'hBEEF);
    check("w16_rx_valid", rx_valid[4], 1'b1);

    // Reset in the middle of a frame
    push(4, 32'hFFFF);
    cs_low(4);
    xfer(4, 6, 16, 32'h0000, r);
    push(4, 32'h0F0F);
    check("pre_rst_tx_ready", tx_ready[4], 1'b0);
    check("pre_rst_busy", busy[4], 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_miso", miso[4], 1'b0);
    check("mid_rst_miso_oe", miso_oe[4], 1'b0);
    check("mid_rst_busy", busy[4], 1'b0);
    check("mid_rst_tx_ready", tx_ready[4], 1'b1);
    check("mid_rst_rx_valid", rx_valid[4], 1'b0);
    check("mid_rst_rx_data", rx16, 16'h0000);
    check("mid_rst_flags", {overrun[4], underrun[4]}, 2'b00);

    // Release reset with cs_n still low: no frame may start
    u0 = un_cnt[4];
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("cs_low_at_reset_busy", busy[4], 1'b0);
    check("cs_low_at_reset_oe", miso_oe[4], 1'b1);
    check("cs_low_at_reset_underrun", un_cnt[4] - u0, 0);
    cs_n[4] = 1'b1;
    repeat (8) @(negedge clk);
    cs_low(4);
    check("new_fall_busy", busy[4], 1'b1);
    cs_high(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
